// File: rtl/sram_sp_wrapper.sv
// Single-port SRAM wrapper: segment-masked writes, fully pipelined reads, init FSM.
// Define SRAM_SP_INIT_EN to zero-fill the array after every reset before accepting requests.
`timescale 1ns/1ps
module sram_sp_wrapper #(
    parameter int Bits         = 32,
    parameter int Word_Depth   = 256,
    parameter int Add_Width    = 8,
    parameter int Seg_Width    = 8,
    parameter int Read_Latency = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      CEB,
    input  logic                      WEB,
    input  logic [Add_Width-1:0]      A,
    input  logic [Bits-1:0]           D,
    input  logic [Bits/Seg_Width-1:0] BWEB,
    output logic [Bits-1:0]           Q,
    output logic                      Q_VALID,
    output logic                      INIT_DONE
);
    localparam int Segs = Bits / Seg_Width;
    localparam logic [Add_Width:0] DepthW = (Add_Width + 1)'(Word_Depth);

    typedef enum logic {INIT, READY} state_e;

    state_e          state_q;
    logic            init_done_q;
    logic [Bits-1:0] mem [Word_Depth];

    logic            in_range;
    logic            accept;
    logic            wr_acc;
    logic            rd_acc_p0;
    logic [Bits-1:0] rd_word_p0;

    // Out-of-range addresses never touch the array; reads of them return zero.
    assign in_range   = ({1'b0, A} < DepthW);
    assign accept     = !CEB && init_done_q;
    assign wr_acc     = accept && !WEB && in_range;
    assign rd_acc_p0  = accept && WEB;
    assign rd_word_p0 = in_range ? mem[A] : '0;

`ifdef SRAM_SP_INIT_EN
    localparam logic [Add_Width-1:0] LastAddr = Add_Width'(Word_Depth - 1);

    logic [Add_Width-1:0] init_cnt_q;
    logic                 init_wr;

    // Sweep is held off while RST is high so reset alone never alters the array.
    assign init_wr = (state_q == INIT) && !RST;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == LastAddr) begin
                        state_q     <= READY;
                        init_done_q <= 1'b1;
                    end
                end
                READY: begin
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (init_wr) begin
            mem[init_cnt_q] <= '0;
        end else if (wr_acc) begin
            for (int s = 0; s < Segs; s++) begin
                if (!BWEB[s]) begin
                    mem[A][s*Seg_Width +: Seg_Width] <= D[s*Seg_Width +: Seg_Width];
                end
            end
        end
    end
`else
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= INIT;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    state_q     <= READY;
                    init_done_q <= 1'b1;
                end
                READY: begin
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            for (int s = 0; s < Segs; s++) begin
                if (!BWEB[s]) begin
                    mem[A][s*Seg_Width +: Seg_Width] <= D[s*Seg_Width +: Seg_Width];
                end
            end
        end
    end
`endif

    // Read pipeline: stage 0 captures the array word on the accepting edge, the last stage is Q.
    logic [Read_Latency-1:0] pipe_vld_q;
    logic [Read_Latency-1:0] pipe_vld_d;
    logic [Bits-1:0]         pipe_data_q [Read_Latency];
    logic [Bits-1:0]         pipe_data_d [Read_Latency];

    always_comb begin
        pipe_vld_d = '0;
        for (int i = 0; i < Read_Latency; i++) begin
            pipe_data_d[i] = pipe_data_q[i];
        end
        pipe_vld_d[0] = rd_acc_p0;
        if (rd_acc_p0) begin
            pipe_data_d[0] = rd_word_p0;
        end
        for (int i = 1; i < Read_Latency; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            if (pipe_vld_q[i-1]) begin
                pipe_data_d[i] = pipe_data_q[i-1];
            end
        end
    end

    // Data only advances with a valid beat, so Q holds its last result between reads.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < Read_Latency; i++) begin
                pipe_data_q[i] <= '0;
            end
        end else begin
            pipe_vld_q <= pipe_vld_d;
            for (int i = 0; i < Read_Latency; i++) begin
                pipe_data_q[i] <= pipe_data_d[i];
            end
        end
    end

    assign Q         = pipe_data_q[Read_Latency-1];
    assign Q_VALID   = pipe_vld_q[Read_Latency-1];
    assign INIT_DONE = init_done_q;

endmodule

// File: tb/tb_sram_sp_wrapper.sv
// Directed bench for sram_sp_wrapper: instance A uses defaults, instance B uses
// Word_Depth=200 and Read_Latency=3; both share the same request inputs.
`timescale 1ns/1ps
module tb_sram_sp_wrapper;

`ifdef SRAM_SP_INIT_EN
    localparam int INIT_A = 256;
    localparam int INIT_B = 200;
`else
    localparam int INIT_A = 1;
    localparam int INIT_B = 1;
`endif

    logic        CLK;
    logic        RST;
    logic        CEB;
    logic        WEB;
    logic [7:0]  A;
    logic [31:0] D;
    logic [3:0]  BWEB;
    logic [31:0] qa, qb;
    logic        qva, qvb, ida, idb;

    sram_sp_wrapper u_dut_a (
        .CLK(CLK), .RST(RST), .CEB(CEB), .WEB(WEB), .A(A), .D(D), .BWEB(BWEB),
        .Q(qa), .Q_VALID(qva), .INIT_DONE(ida)
    );

    sram_sp_wrapper #(.Word_Depth(200), .Read_Latency(3)) u_dut_b (
        .CLK(CLK), .RST(RST), .CEB(CEB), .WEB(WEB), .A(A), .D(D), .BWEB(BWEB),
        .Q(qb), .Q_VALID(qvb), .INIT_DONE(idb)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        ce;
        logic        wr;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  bweb;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t        vecs[$];
    int          checks;
    int          errors;
    logic [31:0] last_a;
    logic [31:0] last_b;

    function automatic vec_t mk(input logic ce, input logic wr, input logic [7:0] a,
                                input logic [31:0] d, input logic [3:0] bweb,
                                input logic [31:0] exp_a, input logic [31:0] exp_b);
        vec_t v;
        v.ce = ce; v.wr = wr; v.a = a; v.d = d; v.bweb = bweb;
        v.exp_a = exp_a; v.exp_b = exp_b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge CLK);
        CEB = !v.ce; WEB = !v.wr; A = v.a; D = v.d; BWEB = v.bweb;
        @(posedge CLK); #1;
        if (v.ce && !v.wr) begin
            chk({tag, " a.vld"}, 32'(qva), 32'd1);
            chk({tag, " a.q"}, qa, v.exp_a);
            last_a = v.exp_a;
        end else begin
            chk({tag, " a.vld"}, 32'(qva), 32'd0);
            chk({tag, " a.hold"}, qa, last_a);
        end
        @(negedge CLK);
        CEB = 1'b1;
        @(posedge CLK);
        @(posedge CLK); #1;
        if (v.ce && !v.wr) begin
            chk({tag, " b.vld"}, 32'(qvb), 32'd1);
            chk({tag, " b.q"}, qb, v.exp_b);
            last_b = v.exp_b;
        end else begin
            chk({tag, " b.vld"}, 32'(qvb), 32'd0);
            chk({tag, " b.hold"}, qb, last_b);
        end
    endtask

    // Releases RST and counts edges until each INIT_DONE rises (0 = never within the budget).
    task automatic run_init(input bit drive_reads, output int ea, output int eb, output int nvld);
        ea = 0; eb = 0; nvld = 0;
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 1; k <= 400 && (ea == 0 || eb == 0); k++) begin
            if (drive_reads && !ida && !idb) begin
                CEB = 1'b0; WEB = 1'b1; A = 8'h00;
            end else begin
                CEB = 1'b1;
            end
            @(posedge CLK); #1;
            if (qva || qvb) nvld++;
            if (ea == 0 && ida) ea = k;
            if (eb == 0 && idb) eb = k;
            @(negedge CLK);
        end
        CEB = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ea, eb, nv;
        checks = 0; errors = 0;
        last_a = '0; last_b = '0;
        RST = 1'b1; CEB = 1'b1; WEB = 1'b1; A = '0; D = '0; BWEB = '0;

`ifdef SRAM_SP_INIT_EN
        vecs.push_back(mk(1, 0, 8'h80, 32'h0,        4'h0, 32'h00000000, 32'h00000000));
`endif
        vecs.push_back(mk(1, 1, 8'h10, 32'hFFFFFFFF, 4'h0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 1, 8'h10, 32'h12345678, 4'hA, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 8'h10, 32'h0,        4'h0, 32'hFF34FF78, 32'hFF34FF78));
        vecs.push_back(mk(0, 1, 8'h10, 32'h00000000, 4'h0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 8'h10, 32'h0,        4'h0, 32'hFF34FF78, 32'hFF34FF78));
        vecs.push_back(mk(0, 0, 8'h10, 32'h0,        4'h0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 1, 8'h05, 32'hCAFEBABE, 4'h0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 8'h05, 32'h0,        4'h0, 32'hCAFEBABE, 32'hCAFEBABE));
        vecs.push_back(mk(1, 1, 8'hF0, 32'hAAAA5555, 4'h0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 8'hF0, 32'h0,        4'h0, 32'hAAAA5555, 32'h00000000));
        vecs.push_back(mk(1, 1, 8'h20, 32'h01020304, 4'h0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 1, 8'h20, 32'hDEADBEEF, 4'hF, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 8'h20, 32'h0,        4'h0, 32'h01020304, 32'h01020304));
        vecs.push_back(mk(1, 1, 8'h20, 32'hA5A5A5A5, 4'h6, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 8'h20, 32'h0,        4'h0, 32'hA50203A5, 32'hA50203A5));
        vecs.push_back(mk(1, 1, 8'hC7, 32'h77777777, 4'h0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 8'hC7, 32'h0,        4'h0, 32'h77777777, 32'h77777777));
        vecs.push_back(mk(1, 1, 8'hFF, 32'h12121212, 4'h0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 8'hFF, 32'h0,        4'h0, 32'h12121212, 32'h00000000));

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst a.q", qa, 32'h0);
        chk("rst a.vld", 32'(qva), 32'd0);
        chk("rst a.done", 32'(ida), 32'd0);
        chk("rst b.q", qb, 32'h0);
        chk("rst b.vld", 32'(qvb), 32'd0);
        chk("rst b.done", 32'(idb), 32'd0);

        // Init sweep with reads offered while not ready
        run_init(1'b1, ea, eb, nv);
        chk("init a.edges", 32'(ea), 32'(INIT_A));
        chk("init b.edges", 32'(eb), 32'(INIT_B));
        chk("init early.vld", 32'(nv), 32'd0);

        foreach (vecs[i]) apply(vecs[i], i);

        // Pipelined reads after back-to-back writes
        @(negedge CLK); CEB = 1'b0; WEB = 1'b0; BWEB = 4'h0; A = 8'd1; D = 32'h11;
        @(negedge CLK); A = 8'd2; D = 32'h22;
        @(negedge CLK); A = 8'd3; D = 32'h33;
        @(negedge CLK); WEB = 1'b1; A = 8'd1;
        @(posedge CLK); #1;
        chk("pipe a.vld1", 32'(qva), 32'd1); chk("pipe a.q1", qa, 32'h11);
        chk("pipe b.vld1", 32'(qvb), 32'd0);
        @(negedge CLK); A = 8'd2;
        @(posedge CLK); #1;
        chk("pipe a.vld2", 32'(qva), 32'd1); chk("pipe a.q2", qa, 32'h22);
        chk("pipe b.vld2", 32'(qvb), 32'd0);
        @(negedge CLK); A = 8'd3;
        @(posedge CLK); #1;
        chk("pipe a.vld3", 32'(qva), 32'd1); chk("pipe a.q3", qa, 32'h33);
        chk("pipe b.vld3", 32'(qvb), 32'd1); chk("pipe b.q3", qb, 32'h11);
        @(negedge CLK); CEB = 1'b1;
        @(posedge CLK); #1;
        chk("pipe a.vld4", 32'(qva), 32'd0); chk("pipe a.hold4", qa, 32'h33);
        chk("pipe b.vld4", 32'(qvb), 32'd1); chk("pipe b.q4", qb, 32'h22);
        @(posedge CLK); #1;
        chk("pipe b.vld5", 32'(qvb), 32'd1); chk("pipe b.q5", qb, 32'h33);
        @(posedge CLK); #1;
        chk("pipe b.vld6", 32'(qvb), 32'd0); chk("pipe b.hold6", qb, 32'h33);

        // Masked write immediately followed by a read of the same word
        @(negedge CLK); CEB = 1'b0; WEB = 1'b0; A = 8'd5; D = 32'h11223344; BWEB = 4'b0101;
        @(negedge CLK); WEB = 1'b1; BWEB = 4'h0;
        @(posedge CLK); #1;
        chk("wtr a.vld", 32'(qva), 32'd1); chk("wtr a.q", qa, 32'h11FE33BE);
        @(negedge CLK); CEB = 1'b1;
        @(posedge CLK);
        @(posedge CLK); #1;
        chk("wtr b.vld", 32'(qvb), 32'd1); chk("wtr b.q", qb, 32'h11FE33BE);

        // Reset with a read in flight in B and a live result on A
        @(negedge CLK); CEB = 1'b0; WEB = 1'b1; A = 8'h10;
        @(posedge CLK); #1;
        CEB = 1'b1;
        chk("rmid a.vld", 32'(qva), 32'd1);
        #2; RST = 1'b1; #1;
        chk("rmid a.vld0", 32'(qva), 32'd0); chk("rmid a.q0", qa, 32'h0);
        chk("rmid b.vld0", 32'(qvb), 32'd0); chk("rmid b.q0", qb, 32'h0);
        chk("rmid a.done0", 32'(ida), 32'd0); chk("rmid b.done0", 32'(idb), 32'd0);
        repeat (2) @(posedge CLK);

        // Partial sweep interrupted at counter 100, then a full restart
        @(negedge CLK); RST = 1'b0;
        repeat (100) @(posedge CLK);
        #2; RST = 1'b1; #1;
        chk("rinit a.done", 32'(ida), 32'd0); chk("rinit b.done", 32'(idb), 32'd0);
        chk("rinit a.vld", 32'(qva), 32'd0);
        repeat (2) @(posedge CLK);
        run_init(1'b0, ea, eb, nv);
        chk("reinit a.edges", 32'(ea), 32'(INIT_A));
        chk("reinit b.edges", 32'(eb), 32'(INIT_B));
        chk("reinit stale.vld", 32'(nv), 32'd0);

        last_a = '0; last_b = '0;
`ifdef SRAM_SP_INIT_EN
        apply(mk(1, 0, 8'h10, 32'h0, 4'h0, 32'h00000000, 32'h00000000), 100);
`else
        apply(mk(1, 0, 8'h10, 32'h0, 4'h0, 32'hFF34FF78, 32'hFF34FF78), 100);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
